// File: rtl/cv32e40p_tmr_spare_voter.sv
// Majority voter over three active slots drawn from 3+NSPARE replicas; retires chronically disagreeing replicas and hot-swaps spares.
// Vote is combinational; remaps and fault flags take effect one cycle after the deciding sample; no backpressure.
module cv32e40p_tmr_spare_voter #(
    parameter  int unsigned NBIT          = 32,
    parameter  int unsigned NSPARE        = 1,
    parameter  int unsigned ERR_THRESHOLD = 4,
    parameter  int unsigned LEAK_EN       = 1,
    localparam int unsigned NREP          = 3 + NSPARE,
    localparam int unsigned CNT_W         = $clog2(ERR_THRESHOLD + 1),
    localparam int unsigned IDX_W         = $clog2(NREP)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sample_i,
    input  logic                  clear_cnt_i,
    input  logic [NREP*NBIT-1:0]  data_i,
    output logic [NBIT-1:0]       dataout_o,
    output logic                  error_detected_o,
    output logic                  uncorrectable_o,
    output logic [NREP-1:0]       faulty_o,
    output logic [3*IDX_W-1:0]    slot_map_o,
    output logic                  swap_o,
    output logic                  spare_exhausted_o
);

    logic [IDX_W-1:0] map_q [3];
    logic [IDX_W-1:0] map_d [3];
    logic [CNT_W-1:0] cnt_q [NREP];
    logic [CNT_W-1:0] cnt_d [NREP];
    logic [NREP-1:0]  faulty_q, faulty_d;
    logic             swap_q, swap_d;
    logic             exh_q, exh_d;

    logic [NBIT-1:0]  sd [3];
    logic [NBIT-1:0]  maj, ha, hb;
    logic [2:0]       healthy, mism, retire;
    logic [1:0]       nh;
    logic             got_a, got_b, disagree;
    logic [NREP-1:0]  avail;
    logic             found;

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            sd[k]      = data_i[NBIT*int'(map_q[k]) +: NBIT];
            healthy[k] = !faulty_q[map_q[k]];
        end
    end

    // Voting: healthy-slot count selects normal / degraded / single behaviour.
    always_comb begin
        maj      = (sd[0] & sd[1]) | (sd[0] & sd[2]) | (sd[1] & sd[2]);
        nh       = 2'(healthy[0]) + 2'(healthy[1]) + 2'(healthy[2]);
        ha       = '0;
        hb       = '0;
        got_a    = 1'b0;
        got_b    = 1'b0;
        mism     = '0;
        disagree = 1'b0;
        dataout_o        = sd[0];
        error_detected_o = 1'b0;
        uncorrectable_o  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (healthy[k]) begin
                if (!got_a) begin
                    ha    = sd[k];
                    got_a = 1'b1;
                end else if (!got_b) begin
                    hb    = sd[k];
                    got_b = 1'b1;
                end
            end
        end
        case (nh)
            2'd3: begin
                dataout_o = maj;
                for (int k = 0; k < 3; k++) mism[k] = (sd[k] != maj);
                error_detected_o = |mism;
            end
            2'd2: begin
                dataout_o        = ha;
                disagree         = (ha != hb);
                error_detected_o = disagree;
                uncorrectable_o  = disagree;
            end
            2'd1:    dataout_o = ha;
            default: dataout_o = sd[0];
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        map_d    = map_q;
        faulty_d = faulty_q;
        swap_d   = 1'b0;
        exh_d    = exh_q;
        retire   = '0;
        avail    = '0;
        found    = 1'b0;
        if (clear_cnt_i) begin
            for (int r = 0; r < NREP; r++) cnt_d[r] = '0;
        end else if (sample_i && !disagree) begin
            // A degraded-mode disagreement cannot be blamed on either slot, so it leaves counters alone.
            for (int k = 0; k < 3; k++) begin
                if (healthy[k]) begin
                    if (mism[k]) begin
                        if (cnt_q[map_q[k]] >= CNT_W'(ERR_THRESHOLD - 1)) begin
                            cnt_d[map_q[k]]    = CNT_W'(ERR_THRESHOLD);
                            faulty_d[map_q[k]] = 1'b1;
                            retire[k]          = 1'b1;
                        end else begin
                            cnt_d[map_q[k]] = cnt_q[map_q[k]] + CNT_W'(1);
                        end
                    end else if (LEAK_EN != 0 && cnt_q[map_q[k]] != '0) begin
                        cnt_d[map_q[k]] = cnt_q[map_q[k]] - CNT_W'(1);
                    end
                end
            end
        end
        avail = ~faulty_d;
        for (int k = 0; k < 3; k++) avail[map_q[k]] = 1'b0;
        // Spares are handed out lowest-index first, in ascending slot order.
        for (int k = 0; k < 3; k++) begin
            if (retire[k]) begin
                found = 1'b0;
                for (int r = 0; r < NREP; r++) begin
                    if (!found && avail[r]) begin
                        map_d[k] = IDX_W'(r);
                        avail[r] = 1'b0;
                        cnt_d[r] = '0;
                        found    = 1'b1;
                        swap_d   = 1'b1;
                    end
                end
                if (!found) exh_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) map_q[k] <= IDX_W'(k);
            for (int r = 0; r < NREP; r++) cnt_q[r] <= '0;
            faulty_q <= '0;
            swap_q   <= 1'b0;
            exh_q    <= 1'b0;
        end else begin
            map_q    <= map_d;
            cnt_q    <= cnt_d;
            faulty_q <= faulty_d;
            swap_q   <= swap_d;
            exh_q    <= exh_d;
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) slot_map_o[k*IDX_W +: IDX_W] = map_q[k];
    end

    assign faulty_o          = faulty_q;
    assign swap_o            = swap_q;
    assign spare_exhausted_o = exh_q;

endmodule
